// File: rtl/shiftreg8_sched_pkg.sv
// Shared types and constants for the shiftreg8_sched delay sequencer.
// Holds the FSM state encoding, the width constants and the tap-validity helper.
package shiftreg8_sched_pkg;

  localparam int DLY_W  = 2;
  localparam int DATA_W = 8;
  localparam int STAGES = 3;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_DRAIN = 1'b1
  } state_e;

  // Delay 0 is a combinational pass-through, so validity comes from the live accept.
  function automatic logic tap_valid(
    input logic [DLY_W-1:0]  sel,
    input logic              acc,
    input logic [STAGES:1]   vld
  );
    logic v;
    case (sel)
      2'd0:    v = acc;
      2'd1:    v = vld[1];
      2'd2:    v = vld[2];
      default: v = vld[3];
    endcase
    return v;
  endfunction

endpackage

// File: rtl/my_dff8.sv
// Plain 8-bit data flop with no enable and no reset.
// Validity is tracked elsewhere, so the data path can stay free-running.
module my_dff8 (
  input  logic       clk,
  input  logic [7:0] d,
  output logic [7:0] q
);

  always_ff @(posedge clk) begin
    q <= d;
  end

endmodule

// File: rtl/shiftreg8_3.sv
// Three-stage 8-bit tapped shift register built from my_dff8.
// sel picks the tap: 0 is the input itself, 1..3 are the stage outputs.
module shiftreg8_3 (
  input  logic       clk,
  input  logic [7:0] d,
  input  logic [1:0] sel,
  output logic [7:0] q
);

  logic [7:0] tap [1:3];

  genvar gi;
  generate
    for (gi = 1; gi <= 3; gi++) begin : g_stage
      if (gi == 1) begin : g_first
        my_dff8 u_dff (
          .clk (clk),
          .d   (d),
          .q   (tap[1])
        );
      end else begin : g_rest
        my_dff8 u_dff (
          .clk (clk),
          .d   (tap[gi-1]),
          .q   (tap[gi])
        );
      end
    end
  endgenerate

  always_comb begin
    q = d;
    case (sel)
      2'd0:    q = d;
      2'd1:    q = tap[1];
      2'd2:    q = tap[2];
      default: q = tap[3];
    endcase
  end

endmodule

// File: rtl/shiftreg8_sched.sv
// Sequencer for a 0-3 cycle programmable delay line: owns the tap select,
// tracks per-stage validity and drains in-flight samples before a tap change.
import shiftreg8_sched_pkg::*;

module shiftreg8_sched #(
  parameter logic [DLY_W-1:0] RESET_DELAY = 2'd0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  input  logic              cfg_valid,
  input  logic [DLY_W-1:0]  cfg_delay,
  output logic              cfg_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic [DLY_W-1:0]  sel,
  output logic              busy
);

  state_e            state_q, state_d;
  logic [DLY_W-1:0]  sel_q, sel_d;
  logic [DLY_W-1:0]  pending_q, pending_d;
  logic [STAGES:1]   vld_q, vld_d;
  logic              acc;

  assign in_ready  = (state_q == ST_RUN);
  assign cfg_ready = (state_q == ST_RUN);
  assign busy      = (state_q == ST_DRAIN);
  assign sel       = sel_q;
  assign acc       = in_valid & in_ready;
  // During DRAIN the old tap stays selected, so queued samples exit on schedule.
  assign out_valid = tap_valid(sel_q, acc, vld_q);

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    pending_d = pending_q;
    vld_d     = {vld_q[2:1], acc};
    case (state_q)
      ST_RUN: begin
        if (cfg_valid && (cfg_delay != sel_q)) begin
          pending_d = cfg_delay;
          state_d   = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // Switch only once every stage is empty, whatever the current tap.
        if (vld_q == '0) begin
          sel_d   = pending_q;
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_RUN;
      sel_q     <= RESET_DELAY;
      pending_q <= RESET_DELAY;
      vld_q     <= '0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      pending_q <= pending_d;
      vld_q     <= vld_d;
    end
  end

  shiftreg8_3 u_shreg (
    .clk (clk),
    .d   (in_data),
    .sel (sel_q),
    .q   (out_data)
  );

endmodule

// File: tb/tb_shiftreg8_sched.sv
// Scoreboard bench for shiftreg8_sched: directed stimulus pushes expected
// (data, exit cycle) pairs; a negedge monitor pops and compares each output.
module tb_shiftreg8_sched;

  logic       clk;
  logic       reset;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       cfg_valid;
  logic [1:0] cfg_delay;
  logic       cfg_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic [1:0] sel;
  logic       busy;

  typedef struct {
    logic [7:0] data;
    int         due;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;

  shiftreg8_sched #(.RESET_DELAY(2'd0)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .cfg_valid (cfg_valid),
    .cfg_delay (cfg_delay),
    .cfg_ready (cfg_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .sel       (sel),
    .busy      (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
    end
  endtask

  // One clock cycle of stimulus plus the control outputs expected in that cycle.
  task automatic step(input logic rst, input logic iv, input logic [7:0] data,
                      input logic cv, input logic [1:0] cd,
                      input logic e_rdy, input logic e_busy, input logic [1:0] e_sel);
    exp_t e;
    @(posedge clk);
    #1;
    reset     = rst;
    in_valid  = iv;
    in_data   = data;
    cfg_valid = cv;
    cfg_delay = cd;
    #1;
    chk("in_ready", int'(in_ready), int'(e_rdy));
    chk("cfg_ready", int'(cfg_ready), int'(e_rdy));
    chk("busy", int'(busy), int'(e_busy));
    chk("sel", int'(sel), int'(e_sel));
    if (iv && e_rdy && !rst) begin
      e.data = data;
      e.due  = cyc + int'(e_sel);
      sb.push_back(e);
    end
  endtask

  always @(negedge clk) begin
    if (out_valid) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL spurious_out cyc=%0d actual=%02h required=none", cyc, out_data);
      end else begin
        exp_t e;
        e = sb.pop_front();
        $display("txn out cyc=%0d data=%02h (expected %02h at cyc %0d)", cyc, out_data, e.data, e.due);
        chk("out_data", int'(out_data), int'(e.data));
        chk("out_cycle", cyc, e.due);
      end
    end
  end

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_data = 8'h00; cfg_valid = 1'b0; cfg_delay = 2'd0;

    // Reset state
    step(1, 0, 8'h00, 0, 0, 1, 0, 0);
    step(1, 0, 8'h00, 0, 0, 1, 0, 0);
    step(0, 0, 8'h00, 0, 0, 1, 0, 0);
    chk("out_valid_after_reset", int'(out_valid), 0);

    // Pass-through ramp at delay 0
    for (int i = 0; i < 8; i++) step(0, 1, 8'(i), 0, 0, 1, 0, 0);

    // Switch 0->3 while streaming: full pipeline, four drain cycles
    step(0, 1, 8'h08, 1, 2'd3, 1, 0, 0);
    repeat (4) step(0, 1, 8'hEE, 0, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 8'h20 + 8'(i), 0, 0, 1, 0, 3);

    // Switch 3->1: 0x10-0x12 exit at delay 3, then 0x13.. at delay 1
    step(0, 1, 8'h10, 0, 0, 1, 0, 3);
    step(0, 1, 8'h11, 0, 0, 1, 0, 3);
    step(0, 1, 8'h12, 1, 2'd1, 1, 0, 3);
    repeat (4) step(0, 1, 8'hEE, 0, 0, 0, 1, 3);
    for (int i = 3; i < 6; i++) step(0, 1, 8'h10 + 8'(i), 0, 0, 1, 0, 1);

    // Request equal to current delay: plain acknowledge, no drain
    step(0, 1, 8'h16, 1, 2'd1, 1, 0, 1);
    step(0, 1, 8'h17, 0, 0, 1, 0, 1);

    // Idle pipeline, then switch 1->2: single drain cycle
    repeat (3) step(0, 0, 8'h00, 0, 0, 1, 0, 1);
    step(0, 0, 8'h00, 1, 2'd2, 1, 0, 1);
    step(0, 0, 8'h00, 0, 0, 0, 1, 1);

    // Stream at delay 2, sample and cfg (->0) in the same cycle
    step(0, 1, 8'h30, 0, 0, 1, 0, 2);
    step(0, 1, 8'h31, 0, 0, 1, 0, 2);
    step(0, 1, 8'h32, 0, 0, 1, 0, 2);
    step(0, 1, 8'h33, 1, 2'd0, 1, 0, 2);
    repeat (4) step(0, 1, 8'hEE, 0, 0, 0, 1, 2);
    step(0, 1, 8'h34, 0, 0, 1, 0, 0);
    step(0, 1, 8'h35, 0, 0, 1, 0, 0);

    // Move to delay 3, then reset on the second drain cycle of a 3->1 switch
    repeat (3) step(0, 0, 8'h00, 0, 0, 1, 0, 0);
    step(0, 0, 8'h00, 1, 2'd3, 1, 0, 0);
    step(0, 0, 8'h00, 0, 0, 0, 1, 0);
    step(0, 1, 8'h40, 0, 0, 1, 0, 3);
    step(0, 1, 8'h41, 0, 0, 1, 0, 3);
    step(0, 1, 8'h42, 1, 2'd1, 1, 0, 3);
    step(0, 0, 8'h00, 0, 0, 0, 1, 3);
    step(1, 0, 8'h00, 0, 0, 0, 1, 3);
    step(0, 0, 8'h00, 0, 0, 1, 0, 0);
    chk("out_valid_after_mid_drain_reset", int'(out_valid), 0);
    // 0x42 was still in flight and is discarded by the reset
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].due >= cyc) sb.delete(i);
    end

    // Pending change must be gone: stays at delay 0
    for (int i = 0; i < 5; i++) step(0, 1, 8'h50 + 8'(i), 0, 0, 1, 0, 0);
    repeat (4) step(0, 0, 8'h00, 0, 0, 1, 0, 0);

    chk("scoreboard_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
